// File: rtl/mcb_arb_pkg.sv
// Shared FSM state encoding and MCB instruction codes for the port command arbiter.
package mcb_arb_pkg;

    typedef enum logic [1:0] {
        WAIT_CAL = 2'd0,
        ARB      = 2'd1,
        ISSUE    = 2'd2,
        GAP      = 2'd3
    } arb_state_e;

    localparam logic [2:0] MCB_INSTR_WR = 3'b000;
    localparam logic [2:0] MCB_INSTR_RD = 3'b001;

    // 64-bit ports need 8-byte alignment, 32-bit ports need 4-byte alignment.
    function automatic logic addr_misaligned(input logic [2:0] low, input bit port_64);
        return port_64 ? (low != 3'b000) : (low[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mcb_port_cmd_arbiter_if.sv
// Command-path signals between the two requesters, the arbiter and the MCB command port.
interface mcb_port_cmd_arbiter_if #(
    parameter int unsigned ADDR_BITS = 30
);
    logic                 mem_calib_done;
    logic                 port_cmd_full;
    logic                 port_cmd_en;
    logic [2:0]           port_cmd_instr;
    logic [5:0]           port_cmd_bl;
    logic [ADDR_BITS-1:0] port_cmd_byte_addr;

    logic                 r0_cmd_req;
    logic [2:0]           r0_cmd_instr;
    logic [5:0]           r0_cmd_bl;
    logic [ADDR_BITS-1:0] r0_cmd_byte_addr;
    logic                 r0_cmd_ack;

    logic                 r1_cmd_req;
    logic [2:0]           r1_cmd_instr;
    logic [5:0]           r1_cmd_bl;
    logic [ADDR_BITS-1:0] r1_cmd_byte_addr;
    logic                 r1_cmd_ack;

    logic                 grant_id;
    logic                 busy;
    logic                 err_align;

    modport master (
        output mem_calib_done, port_cmd_full,
        output r0_cmd_req, r0_cmd_instr, r0_cmd_bl, r0_cmd_byte_addr,
        output r1_cmd_req, r1_cmd_instr, r1_cmd_bl, r1_cmd_byte_addr,
        input  port_cmd_en, port_cmd_instr, port_cmd_bl, port_cmd_byte_addr,
        input  r0_cmd_ack, r1_cmd_ack, grant_id, busy, err_align
    );

    modport slave (
        input  mem_calib_done, port_cmd_full,
        input  r0_cmd_req, r0_cmd_instr, r0_cmd_bl, r0_cmd_byte_addr,
        input  r1_cmd_req, r1_cmd_instr, r1_cmd_bl, r1_cmd_byte_addr,
        output port_cmd_en, port_cmd_instr, port_cmd_bl, port_cmd_byte_addr,
        output r0_cmd_ack, r1_cmd_ack, grant_id, busy, err_align
    );

endinterface

// File: rtl/mcb_port_cmd_arbiter.sv
// Two-requester arbiter for one MCB command port: fixed priority to r0 (display reads)
// with a starvation guard that forces an r1 grant after MAX_CONSEC back-to-back r0 grants.
module mcb_port_cmd_arbiter
    import mcb_arb_pkg::*;
#(
    parameter int unsigned MAX_CONSEC   = 4,
    parameter bit          PORT_64_BITS = 1'b0,
    parameter int unsigned ADDR_BITS    = 30
) (
    input logic                   clk,
    input logic                   reset_n,
    mcb_port_cmd_arbiter_if.slave bus
);

    localparam int unsigned     CntW   = $clog2(MAX_CONSEC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_CONSEC);

    arb_state_e           state;
    logic [CntW-1:0]      starve_cnt;
    logic                 cmd_en_q;
    logic                 ack0_q;
    logic                 ack1_q;
    logic                 grant_q;
    logic                 err_q;
    logic [2:0]           instr_q;
    logic [5:0]           bl_q;
    logic [ADDR_BITS-1:0] addr_q;

    logic                 pick_r1;
    logic [2:0]           win_instr;
    logic [5:0]           win_bl;
    logic [ADDR_BITS-1:0] win_addr;

    always_comb begin
        pick_r1   = bus.r1_cmd_req && (!bus.r0_cmd_req || (starve_cnt == CntMax));
        win_instr = pick_r1 ? bus.r1_cmd_instr : bus.r0_cmd_instr;
        win_bl    = pick_r1 ? bus.r1_cmd_bl : bus.r0_cmd_bl;
        win_addr  = pick_r1 ? bus.r1_cmd_byte_addr : bus.r0_cmd_byte_addr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_CAL;
            starve_cnt <= '0;
            cmd_en_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            grant_q    <= 1'b0;
            err_q      <= 1'b0;
            instr_q    <= '0;
            bl_q       <= '0;
            addr_q     <= '0;
        end else begin
            cmd_en_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            unique case (state)
                WAIT_CAL: if (bus.mem_calib_done) state <= ARB;
                ARB: begin
                    if (!bus.r1_cmd_req) starve_cnt <= '0;
                    if (!bus.mem_calib_done) begin
                        state <= WAIT_CAL;
                    end else if (!bus.port_cmd_full && (bus.r0_cmd_req || bus.r1_cmd_req)) begin
                        state    <= ISSUE;
                        cmd_en_q <= 1'b1;
                        ack0_q   <= !pick_r1;
                        ack1_q   <= pick_r1;
                        grant_q  <= pick_r1;
                        instr_q  <= win_instr;
                        bl_q     <= win_bl;
                        addr_q   <= win_addr;
                        // Flag is raised alongside cmd_en; the command still goes out.
                        err_q    <= err_q | addr_misaligned(win_addr[2:0], PORT_64_BITS);
                        if (pick_r1) begin
                            starve_cnt <= '0;
                        end else if (bus.r1_cmd_req && (starve_cnt != CntMax)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ISSUE:   state <= GAP;
                GAP:     state <= ARB;
                default: state <= WAIT_CAL;
            endcase
        end
    end

    assign bus.port_cmd_en        = cmd_en_q;
    assign bus.port_cmd_instr     = instr_q;
    assign bus.port_cmd_bl        = bl_q;
    assign bus.port_cmd_byte_addr = addr_q;
    assign bus.r0_cmd_ack         = ack0_q;
    assign bus.r1_cmd_ack         = ack1_q;
    assign bus.grant_id           = grant_q;
    assign bus.busy               = (state == ISSUE) || (state == GAP);
    assign bus.err_align          = err_q;

endmodule

// File: tb/tb_mcb_port_cmd_arbiter.sv
// Randomised bench for mcb_port_cmd_arbiter, checked every cycle against a transaction-level model.
module tb_mcb_port_cmd_arbiter;
    import mcb_arb_pkg::*;

    localparam int MaxConsec = 4;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   en_cnt = 0;
    int   ack_cnt = 0;

    mcb_port_cmd_arbiter_if #(.ADDR_BITS(30)) bus ();

    mcb_port_cmd_arbiter #(
        .MAX_CONSEC  (MaxConsec),
        .PORT_64_BITS(1'b0),
        .ADDR_BITS   (30)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: after a grant the port is unavailable for two more edges
    // (the issue cycle and one gap cycle); otherwise it decides every cycle it is calibrated.
    logic        m_en, m_ack0, m_ack1, m_grant, m_err;
    logic [2:0]  m_instr;
    logic [5:0]  m_bl;
    logic [29:0] m_addr;
    int          m_hold, m_starve;
    bit          m_cal_ok;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_en = 0; m_ack0 = 0; m_ack1 = 0; m_grant = 0; m_err = 0;
                m_instr = 0; m_bl = 0; m_addr = 0;
                m_hold = 0; m_starve = 0; m_cal_ok = 0;
            end else begin
                m_en = 0; m_ack0 = 0; m_ack1 = 0;
                if (m_hold > 0) begin
                    m_hold--;
                end else if (!m_cal_ok) begin
                    m_cal_ok = bus.mem_calib_done;
                end else begin
                    if (!bus.r1_cmd_req) m_starve = 0;
                    if (!bus.mem_calib_done) begin
                        m_cal_ok = 0;
                    end else if (!bus.port_cmd_full && (bus.r0_cmd_req || bus.r1_cmd_req)) begin
                        bit w;
                        w = bus.r1_cmd_req && (!bus.r0_cmd_req || m_starve == MaxConsec);
                        m_en = 1; m_ack0 = !w; m_ack1 = w; m_grant = w;
                        m_instr = w ? bus.r1_cmd_instr : bus.r0_cmd_instr;
                        m_bl    = w ? bus.r1_cmd_bl : bus.r0_cmd_bl;
                        m_addr  = w ? bus.r1_cmd_byte_addr : bus.r0_cmd_byte_addr;
                        if (m_addr % 4 != 0) m_err = 1;
                        if (w) m_starve = 0;
                        else if (bus.r1_cmd_req && m_starve < MaxConsec) m_starve++;
                        m_hold = 2;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("cmd_en", 32'(bus.port_cmd_en), 32'(m_en));
                chk("ack0", 32'(bus.r0_cmd_ack), 32'(m_ack0));
                chk("ack1", 32'(bus.r1_cmd_ack), 32'(m_ack1));
                chk("instr", 32'(bus.port_cmd_instr), 32'(m_instr));
                chk("bl", 32'(bus.port_cmd_bl), 32'(m_bl));
                chk("addr", 32'(bus.port_cmd_byte_addr), 32'(m_addr));
                chk("grant_id", 32'(bus.grant_id), 32'(m_grant));
                chk("busy", 32'(bus.busy), 32'(m_hold > 0));
                chk("err_align", 32'(bus.err_align), 32'(m_err));
                if (bus.port_cmd_en) en_cnt++;
                if (bus.r0_cmd_ack || bus.r1_cmd_ack) ack_cnt++;
            end
        end
    end

    task automatic set_req(input int r, input logic [2:0] ins, input logic [5:0] bl,
                           input logic [29:0] a);
        if (r == 0) begin
            bus.r0_cmd_req = 1; bus.r0_cmd_instr = ins; bus.r0_cmd_bl = bl;
            bus.r0_cmd_byte_addr = a;
        end else begin
            bus.r1_cmd_req = 1; bus.r1_cmd_instr = ins; bus.r1_cmd_bl = bl;
            bus.r1_cmd_byte_addr = a;
        end
    endtask

    task automatic rand_req(input int r, input bit allow_bad);
        logic [29:0] a;
        a = 30'($urandom);
        if (!(allow_bad && $urandom_range(0, 19) == 0)) a[1:0] = 2'b00;
        set_req(r, 3'($urandom_range(0, 7)), 6'($urandom), a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample acks mid-cycle, then update requesters just after the next edge.
    task automatic rand_step();
        bit a0, a1;
        @(negedge clk);
        a0 = bus.r0_cmd_ack;
        a1 = bus.r1_cmd_ack;
        tick();
        if (a0) begin
            if ($urandom_range(0, 1) == 1) rand_req(0, 1); else bus.r0_cmd_req = 0;
        end else if (!bus.r0_cmd_req && $urandom_range(0, 99) < 40) rand_req(0, 1);
        if (a1) begin
            if ($urandom_range(0, 1) == 1) rand_req(1, 1); else bus.r1_cmd_req = 0;
        end else if (!bus.r1_cmd_req && $urandom_range(0, 99) < 40) rand_req(1, 1);
        bus.port_cmd_full = ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 99) < 2) bus.mem_calib_done = !bus.mem_calib_done;
    endtask

    initial begin
        int n, last, seen;
        bit a0, a1, found;
        logic [31:0] exp_pat [10];
        logic [31:0] got_pat [10];
        exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        reset_n = 0;
        bus.mem_calib_done = 0; bus.port_cmd_full = 0;
        bus.r0_cmd_req = 0; bus.r0_cmd_instr = 0; bus.r0_cmd_bl = 0; bus.r0_cmd_byte_addr = 0;
        bus.r1_cmd_req = 0; bus.r1_cmd_instr = 0; bus.r1_cmd_bl = 0; bus.r1_cmd_byte_addr = 0;
        set_req(0, MCB_INSTR_RD, 6'd7, 30'h0000_0A00);
        repeat (3) tick();
        reset_n = 1;

        // 1: no command until calibration, then first command on the second edge.
        repeat (5) tick();
        @(negedge clk);
        chk("t1_no_cmd_before_cal", 32'(bus.port_cmd_en), 32'd0);
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);
        tick();
        bus.mem_calib_done = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t1_cmd_en", 32'(bus.port_cmd_en), 32'd1);
        chk("t1_addr", 32'(bus.port_cmd_byte_addr), 32'h0000_0A00);
        chk("t1_ack0", 32'(bus.r0_cmd_ack), 32'd1);
        chk("t1_instr", 32'(bus.port_cmd_instr), 32'(MCB_INSTR_RD));
        tick();
        bus.r0_cmd_req = 0;
        repeat (4) tick();

        // 2: both requesting continuously -> starvation guard pattern, one command per 3 cycles.
        rand_req(0, 0);
        rand_req(1, 0);
        n = 0; last = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            a0 = 0; a1 = 0;
            if (bus.port_cmd_en) begin
                got_pat[n] = 32'(bus.grant_id);
                if (n > 0) chk("t2_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                n++;
                a0 = bus.r0_cmd_ack; a1 = bus.r1_cmd_ack;
            end
            tick();
            if (a0) rand_req(0, 0);
            if (a1) rand_req(1, 0);
        end
        chk("t2_grant_count", 32'(n), 32'd10);
        for (int i = 0; i < n; i++) chk($sformatf("t2_grant%0d", i), got_pat[i], exp_pat[i]);
        bus.r0_cmd_req = 0; bus.r1_cmd_req = 0;
        repeat (4) tick();

        // 3: full stalls a pending r1 request; fields issue unchanged once full clears.
        bus.port_cmd_full = 1;
        set_req(1, MCB_INSTR_WR, 6'h3F, 30'h0123_4560);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.port_cmd_en || bus.r1_cmd_ack) seen++;
            tick();
        end
        chk("t3_stalled", 32'(seen), 32'd0);
        bus.port_cmd_full = 0;
        found = 0;
        for (int c = 0; c < 4 && !found; c++) begin
            @(negedge clk);
            if (bus.port_cmd_en) begin
                found = 1;
                chk("t3_grant", 32'(bus.grant_id), 32'd1);
                chk("t3_addr", 32'(bus.port_cmd_byte_addr), 32'h0123_4560);
                chk("t3_bl", 32'(bus.port_cmd_bl), 32'h3F);
            end
            tick();
        end
        chk("t3_issued", 32'(found), 32'd1);
        bus.r1_cmd_req = 0;
        repeat (3) tick();

        // 4: calibration lost during the gap holds off the next request until it returns.
        set_req(0, MCB_INSTR_RD, 6'd1, 30'h0000_0100);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = bus.port_cmd_en;
            tick();
        end
        chk("t4_first", 32'(found), 32'd1);
        bus.mem_calib_done = 0;
        set_req(0, MCB_INSTR_RD, 6'd2, 30'h0000_0200);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.port_cmd_en) seen++;
            tick();
        end
        chk("t4_held", 32'(seen), 32'd0);
        chk("t4_not_busy", 32'(bus.busy), 32'd0);
        bus.mem_calib_done = 1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a0 = bus.r0_cmd_ack;
            if (bus.port_cmd_en) begin
                seen++;
                chk("t4_addr", 32'(bus.port_cmd_byte_addr), 32'h0000_0200);
            end
            tick();
            if (a0) bus.r0_cmd_req = 0;
        end
        chk("t4_once", 32'(seen), 32'd1);

        // 5: misaligned address is still issued and latches err_align.
        chk("t5_err_before", 32'(bus.err_align), 32'd0);
        set_req(1, MCB_INSTR_WR, 6'd0, 30'h0000_0002);
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = bus.port_cmd_en;
            tick();
        end
        chk("t5_issued", 32'(found), 32'd1);
        bus.r1_cmd_req = 0;
        repeat (6) tick();
        chk("t5_err_sticky", 32'(bus.err_align), 32'd1);

        // Random traffic with full/calibration noise.
        for (int c = 0; c < 3000; c++) rand_step();

        // 6: async reset in the issue cycle clears every output immediately.
        bus.mem_calib_done = 1; bus.port_cmd_full = 0;
        bus.r0_cmd_req = 0; bus.r1_cmd_req = 0;
        repeat (4) tick();
        set_req(0, MCB_INSTR_RD, 6'd5, 30'h0000_0040);
        found = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            tick();
            found = bus.port_cmd_en;
        end
        chk("t6_reached_issue", 32'(found), 32'd1);
        reset_n = 0;
        #1;
        chk("t6_cmd_en", 32'(bus.port_cmd_en), 32'd0);
        chk("t6_ack0", 32'(bus.r0_cmd_ack), 32'd0);
        chk("t6_addr", 32'(bus.port_cmd_byte_addr), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_err", 32'(bus.err_align), 32'd0);
        chk("t6_grant", 32'(bus.grant_id), 32'd0);
        bus.r0_cmd_req = 0;
        repeat (3) tick();
        reset_n = 1;
        repeat (5) tick();
        chk("ack_vs_cmd_en", 32'(ack_cnt), 32'(en_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
